// File: rtl/bus_sram_slave_if.sv
// Bus between a master and the SRAM slave window.
// Master drives: begin_transaction, end_transaction, read_write (1 = read), data_valid,
//   address_data (address on begin, write data otherwise), burst_size (words - 1),
//   byte_enable.
// Slave drives: out_data_valid, out_end_transaction, out_error, out_busy,
//   out_address_data (read data, 0 when out_data_valid is low).
interface bus_sram_slave_if;
   logic        begin_transaction;
   logic        end_transaction;
   logic        read_write;
   logic        data_valid;
   logic [31:0] address_data;
   logic [7:0]  burst_size;
   logic [3:0]  byte_enable;

   logic        out_data_valid;
   logic        out_end_transaction;
   logic        out_error;
   logic        out_busy;
   logic [31:0] out_address_data;

   modport master (
      output begin_transaction, end_transaction, read_write, data_valid,
             address_data, burst_size, byte_enable,
      input  out_data_valid, out_end_transaction, out_error, out_busy, out_address_data
   );

   modport slave (
      input  begin_transaction, end_transaction, read_write, data_valid,
             address_data, burst_size, byte_enable,
      output out_data_valid, out_end_transaction, out_error, out_busy, out_address_data
   );
endinterface

// File: rtl/bus_sram_slave.sv
// Burst-capable SRAM slave mapped at a word-aligned window of the bus.
// Ports:
//   clk_i  - single clock, all state on the rising edge
//   rst_i  - asynchronous active-high reset (memory contents are kept)
//   bus_io - slave side of bus_sram_slave_if
// Reads return the first word two cycles after begin, then one word per cycle, followed
// by a one-cycle end pulse. Writes accept a word whenever data_valid is high and busy is
// low; WriteThrottle > 0 inserts a busy cycle after every WriteThrottle accepted words.
// Out-of-range bursts and write overflows produce a one-cycle error + end pulse.
module bus_sram_slave #(
   parameter logic [31:0] BaseAddress   = 32'h5000_0000,
   parameter int unsigned NrOfEntries   = 512,
   parameter int unsigned WriteThrottle = 0
) (
   input logic              clk_i,
   input logic              rst_i,
   bus_sram_slave_if.slave  bus_io
);

   localparam int unsigned IdxW = (NrOfEntries > 1) ? $clog2(NrOfEntries) : 1;

   typedef enum logic [1:0] {StIdle, StRead, StWrite, StError} state_e;

   state_e          state_q, state_d;
   logic [IdxW-1:0] idx_q, idx_d;
   logic [7:0]      burst_q, burst_d;
   logic [8:0]      cnt_q, cnt_d;     // words transferred so far in this burst
   logic [3:0]      be_q, be_d;
   logic [15:0]     thr_q, thr_d;     // accepted words since the last busy cycle
   logic            valid_q, valid_d;
   logic            end_q, end_d;
   logic            err_q, err_d;
   logic            busy_q, busy_d;
   logic [31:0]     data_q, data_d;

   logic [31:0]     mem_q [NrOfEntries];

   logic [29:0]     offset;
   logic            hit, range_err, start, word_ok, overflow, accept;
   logic            rd_issue, rd_last, thr_hit, err_enter;

   // Word offset from the window base; a wrap below the base yields a huge value -> miss.
   assign offset    = bus_io.address_data[31:2] - BaseAddress[31:2];
   assign hit       = {2'b00, offset} < NrOfEntries;
   assign range_err = ({2'b00, offset} + 32'(bus_io.burst_size)) >= NrOfEntries;
   assign start     = (state_q == StIdle) && bus_io.begin_transaction && hit;

   assign word_ok   = (state_q == StWrite) && bus_io.data_valid && !busy_q;
   assign overflow  = word_ok && (cnt_q > {1'b0, burst_q});
   assign accept    = word_ok && !overflow;

   // A master end during a read aborts it: no further words and no slave end pulse.
   assign rd_issue  = (state_q == StRead) && !bus_io.end_transaction &&
                      (cnt_q <= {1'b0, burst_q});
   assign rd_last   = (state_q == StRead) && !bus_io.end_transaction &&
                      (cnt_q > {1'b0, burst_q});

   assign thr_hit   = accept && (WriteThrottle != 0) && (thr_q == 16'(WriteThrottle - 1));
   assign err_enter = (start && range_err) || overflow;

   // State register
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   // Next-state logic
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle: begin
            if (start) begin
               if (range_err) begin
                  state_d = StError;
               end else if (bus_io.read_write) begin
                  state_d = StRead;
               end else begin
                  state_d = StWrite;
               end
            end
         end
         StRead: begin
            if (bus_io.end_transaction || rd_last) begin
               state_d = StIdle;
            end
         end
         StWrite: begin
            // A word presented with end is accepted first, so only overflow takes priority.
            if (overflow) begin
               state_d = StError;
            end else if (bus_io.end_transaction) begin
               state_d = StIdle;
            end
         end
         StError: state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   // Output next-values (all outputs leave through registers)
   always_comb begin
      valid_d = rd_issue;
      end_d   = rd_last || err_enter;
      err_d   = err_enter;
      busy_d  = thr_hit;
      data_d  = '0;
      if (rd_issue) begin
         data_d = mem_q[idx_q];
      end
   end

   // Burst bookkeeping
   always_comb begin
      idx_d   = idx_q;
      burst_d = burst_q;
      cnt_d   = cnt_q;
      be_d    = be_q;
      thr_d   = thr_q;
      if (start) begin
         idx_d   = offset[IdxW-1:0];
         burst_d = bus_io.burst_size;
         be_d    = bus_io.byte_enable;
         cnt_d   = '0;
         thr_d   = '0;
      end else if (rd_issue || accept) begin
         idx_d = idx_q + 1'b1;
         cnt_d = cnt_q + 9'd1;
      end
      if (accept) begin
         thr_d = thr_hit ? '0 : thr_q + 16'd1;
      end
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         idx_q   <= '0;
         burst_q <= '0;
         cnt_q   <= '0;
         be_q    <= '0;
         thr_q   <= '0;
         valid_q <= 1'b0;
         end_q   <= 1'b0;
         err_q   <= 1'b0;
         busy_q  <= 1'b0;
         data_q  <= '0;
      end else begin
         idx_q   <= idx_d;
         burst_q <= burst_d;
         cnt_q   <= cnt_d;
         be_q    <= be_d;
         thr_q   <= thr_d;
         valid_q <= valid_d;
         end_q   <= end_d;
         err_q   <= err_d;
         busy_q  <= busy_d;
         data_q  <= data_d;
      end
   end

   // Storage is deliberately outside the reset domain so contents survive reset.
   always_ff @(posedge clk_i) begin
      if (accept) begin
         for (int b = 0; b < 4; b++) begin
            if (be_q[b]) begin
               mem_q[idx_q][8*b +: 8] <= bus_io.address_data[8*b +: 8];
            end
         end
      end
   end

   assign bus_io.out_data_valid      = valid_q;
   assign bus_io.out_end_transaction = end_q;
   assign bus_io.out_error           = err_q;
   assign bus_io.out_busy            = busy_q;
   assign bus_io.out_address_data    = data_q;

endmodule

// File: tb/tb_bus_sram_slave.sv
// Scoreboard bench for bus_sram_slave: stimulus tasks push expected output events
// (cycle, flags, data) computed from a word-array model; a negedge monitor pops and
// compares whenever the slave drives any output activity.
module tb_bus_sram_slave;
   localparam logic [31:0] Base     = 32'h5000_0000;
   localparam int          Entries  = 512;
   localparam int          Throttle = 2;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   cyc = 0;
   int   n_checks = 0;
   int   n_fail = 0;

   typedef struct {
      int          cyc;
      bit          v;
      bit          e;
      bit          er;
      bit          b;
      logic [31:0] d;
   } ev_t;

   ev_t         exp_q[$];
   logic [31:0] mdl [Entries];

   bus_sram_slave_if bus ();

   bus_sram_slave #(
      .BaseAddress   (Base),
      .NrOfEntries   (Entries),
      .WriteThrottle (Throttle)
   ) dut (
      .clk_i  (clk),
      .rst_i  (rst),
      .bus_io (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic bus_idle;
      bus.begin_transaction = 1'b0;
      bus.end_transaction   = 1'b0;
      bus.read_write        = 1'b0;
      bus.data_valid        = 1'b0;
      bus.address_data      = '0;
      bus.burst_size        = '0;
      bus.byte_enable       = '0;
   endtask

   task automatic push(int c, bit v, bit e, bit er, bit b, logic [31:0] d);
      ev_t x;
      x.cyc = c; x.v = v; x.e = e; x.er = er; x.b = b; x.d = d;
      exp_q.push_back(x);
   endtask

   // Monitor / scoreboard
   always @(negedge clk) begin
      ev_t x;
      bit  act;
      act = bus.out_data_valid | bus.out_end_transaction | bus.out_error | bus.out_busy;
      if (rst) begin
         n_checks++;
         if (act || bus.out_address_data != 0) begin
            n_fail++;
            $display("FAIL reset_outputs: cyc=%0d got v=%0b e=%0b er=%0b b=%0b d=%h, want all 0",
                     cyc, bus.out_data_valid, bus.out_end_transaction, bus.out_error,
                     bus.out_busy, bus.out_address_data);
         end
      end else if (act) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_output: cyc=%0d got v=%0b e=%0b er=%0b b=%0b d=%h, want none",
                     cyc, bus.out_data_valid, bus.out_end_transaction, bus.out_error,
                     bus.out_busy, bus.out_address_data);
         end else begin
            x = exp_q.pop_front();
            if (x.cyc != cyc || x.v != bus.out_data_valid || x.e != bus.out_end_transaction ||
                x.er != bus.out_error || x.b != bus.out_busy || x.d != bus.out_address_data) begin
               n_fail++;
               $display("FAIL response: got cyc=%0d v=%0b e=%0b er=%0b b=%0b d=%h, want cyc=%0d v=%0b e=%0b er=%0b b=%0b d=%h",
                        cyc, bus.out_data_valid, bus.out_end_transaction, bus.out_error,
                        bus.out_busy, bus.out_address_data, x.cyc, x.v, x.e, x.er, x.b, x.d);
            end
         end
      end else begin
         n_checks++;
         if (bus.out_address_data != 0) begin
            n_fail++;
            $display("FAIL idle_data: cyc=%0d got d=%h, want 0", cyc, bus.out_address_data);
         end
         if (exp_q.size() != 0 && exp_q[0].cyc <= cyc) begin
            x = exp_q.pop_front();
            n_checks++;
            n_fail++;
            $display("FAIL missing_output: cyc=%0d got nothing, want v=%0b e=%0b er=%0b b=%0b d=%h at cyc=%0d",
                     cyc, x.v, x.e, x.er, x.b, x.d, x.cyc);
         end
      end
   end

   // Write burst; the master re-presents a word during any busy cycle the model predicts.
   task automatic do_write(int idx, int burst, logic [3:0] be, int nw, bit ovf, bit seq,
                           logic [31:0] dbase);
      int          acc, k, total;
      bit          busy_now, busy_next, ended, gap;
      logic [31:0] w;
      bus.begin_transaction = 1'b1;
      bus.read_write        = 1'b0;
      bus.address_data      = Base + 32'(4 * idx);
      bus.burst_size        = 8'(burst);
      bus.byte_enable       = be;
      bus.data_valid        = 1'b0;
      bus.end_transaction   = 1'b0;
      if (idx + burst >= Entries) begin
         push(cyc + 1, 0, 1, 1, 0, 0);
         tick; bus_idle; tick;
         return;
      end
      tick;
      bus_idle;
      acc = 0; k = 0; busy_now = 0; ended = 0;
      total = nw + (ovf ? 1 : 0);
      w = seq ? dbase : $urandom;
      while (k < total && !ended) begin
         if (busy_now) push(cyc, 0, 0, 0, 1, 0);
         gap = ($urandom_range(0, 3) == 0);
         bus.data_valid      = !gap;
         bus.address_data    = gap ? $urandom : w;
         bus.end_transaction = 1'b0;
         busy_next = 0;
         if (!gap && !busy_now) begin
            if (k == nw) begin
               push(cyc + 1, 0, 1, 1, 0, 0);
               tick; bus_idle; tick;
               return;
            end
            for (int b = 0; b < 4; b++) begin
               if (be[b]) mdl[idx + k][8*b +: 8] = w[8*b +: 8];
            end
            acc++;
            k++;
            busy_next = (acc % Throttle == 0);
            w = seq ? dbase + 32'(k) : $urandom;
            if (k == nw && !ovf && $urandom_range(0, 1) == 1) begin
               bus.end_transaction = 1'b1;
               ended = 1;
            end
         end
         tick;
         busy_now = busy_next;
      end
      bus_idle;
      if (busy_now) push(cyc, 0, 0, 0, 1, 0);
      if (!ended) begin
         bus.end_transaction = 1'b1;
         tick;
      end
      bus_idle;
      tick;
   endtask

   // Read burst; abort_n >= 0 ends it from the master after abort_n words.
   task automatic do_read(int idx, int burst, int abort_n);
      int c, n;
      c = cyc;
      bus.begin_transaction = 1'b1;
      bus.read_write        = 1'b1;
      bus.address_data      = Base + 32'(4 * idx);
      bus.burst_size        = 8'(burst);
      bus.byte_enable       = 4'($urandom);
      bus.data_valid        = 1'b0;
      bus.end_transaction   = 1'b0;
      if (idx + burst >= Entries) begin
         push(c + 1, 0, 1, 1, 0, 0);
         tick; bus_idle; tick;
         return;
      end
      n = (abort_n < 0) ? burst + 1 : abort_n;
      for (int i = 0; i < n; i++) push(c + 2 + i, 1, 0, 0, 0, mdl[idx + i]);
      if (abort_n < 0) push(c + 3 + burst, 0, 1, 0, 0, 0);
      tick;
      // A begin while busy with a burst must be ignored.
      bus.begin_transaction = ($urandom_range(0, 1) == 1);
      bus.read_write        = ($urandom_range(0, 1) == 1);
      bus.address_data      = Base + 32'(4 * $urandom_range(0, Entries - 1));
      if (abort_n >= 0) begin
         while (cyc < c + 1 + abort_n) begin
            tick;
            bus_idle;
         end
         bus.end_transaction = 1'b1;
         tick; bus_idle; tick;
      end else begin
         tick;
         bus_idle;
         while (cyc < c + 4 + burst) tick;
      end
   endtask

   task automatic do_miss;
      bus.begin_transaction = 1'b1;
      bus.read_write        = ($urandom_range(0, 1) == 1);
      bus.burst_size        = 8'($urandom_range(0, 7));
      bus.byte_enable       = 4'hF;
      if ($urandom_range(0, 1) == 1) bus.address_data = Base - 32'(4 * $urandom_range(1, 64));
      else bus.address_data = Base + 32'(4 * Entries) + 32'(4 * $urandom_range(0, 64));
      tick; bus_idle; tick; tick;
   endtask

   task automatic reset_mid_read;
      int c;
      c = cyc;
      bus.begin_transaction = 1'b1;
      bus.read_write        = 1'b1;
      bus.address_data      = Base;
      bus.burst_size        = 8'd7;
      bus.byte_enable       = 4'hF;
      push(c + 2, 1, 0, 0, 0, mdl[0]);
      tick; bus_idle; tick; tick;
      rst = 1'b1;
      #1;
      n_checks++;
      if (bus.out_data_valid || bus.out_end_transaction || bus.out_error || bus.out_busy ||
          bus.out_address_data != 0) begin
         n_fail++;
         $display("FAIL reset_mid_burst: got v=%0b e=%0b er=%0b b=%0b d=%h, want all 0",
                  bus.out_data_valid, bus.out_end_transaction, bus.out_error, bus.out_busy,
                  bus.out_address_data);
      end
      tick; tick;
      rst = 1'b0;
      tick;
   endtask

   initial begin
      int kind, idx, burst, nw, abort_n;
      bit ovf;
      bus_idle;
      rst = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      rst = 1'b0;
      tick;

      do_write(0, 255, 4'hF, 256, 0, 0, 0);
      do_write(256, 255, 4'hF, 256, 0, 0, 0);

      do_write(2, 3, 4'hF, 4, 0, 1, 32'd1);
      do_read(2, 3, -1);
      do_write(510, 3, 4'hF, 4, 0, 0, 0);
      do_read(508, 3, -1);
      do_write(20, 0, 4'hF, 1, 0, 1, 32'h1122_3344);
      do_write(20, 0, 4'b0011, 1, 0, 1, 32'hAABB_CCDD);
      do_read(20, 0, -1);
      do_write(40, 5, 4'hF, 6, 1, 0, 0);
      do_read(38, 9, -1);
      do_read(100, 6, 3);
      do_miss;

      reset_mid_read;
      do_read(0, 7, -1);

      for (int t = 0; t < 80; t++) begin
         kind  = $urandom_range(0, 9);
         idx   = $urandom_range(0, Entries - 1);
         burst = ($urandom_range(0, 9) == 0) ? $urandom_range(0, 255) : $urandom_range(0, 15);
         if (kind <= 3) begin
            nw  = $urandom_range(1, burst + 1);
            ovf = (nw == burst + 1) && ($urandom_range(0, 2) == 0);
            do_write(idx, burst, 4'($urandom), nw, ovf, 0, 0);
         end else if (kind <= 7) begin
            abort_n = ($urandom_range(0, 3) == 0) ? $urandom_range(0, burst) : -1;
            do_read(idx, burst, abort_n);
         end else if (kind == 8) begin
            do_miss;
         end else begin
            idx   = Entries - 1 - $urandom_range(0, 3);
            burst = $urandom_range(4, 20);
            if ($urandom_range(0, 1) == 1) do_read(idx, burst, -1);
            else do_write(idx, burst, 4'hF, 1, 0, 0, 0);
         end
      end

      repeat (5) tick;
      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL drain: got %0d pending events, want 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule

// File: doc/bus_sram_slave.md
BUS_SRAM_SLAVE -- requirements
Module: busSramSlave

Interface
REQ-001 SHALL have parameter baseAddress, default 32'h50000000; byte base of the slave window, 2 KiB aligned.
REQ-002 SHALL have parameter nrOfEntries, default 512; number of 32-bit words in the window.
REQ-003 SHALL have parameter writeThrottle, default 0; when N>0, assert busy for 1 cycle after every N accepted write words; 0 means never.
REQ-004 clock  in  1  single clock; all state updates on rising edge.
REQ-005 reset  in  1  asynchronous, active-high.
REQ-006 in_busBeginTransaction  in  1  master starts a transaction; address is valid this cycle.
REQ-007 in_busEndTransaction  in  1  master ends a write burst, or aborts.
REQ-008 in_busReadWrite  in  1  1 = master reads from slave; 0 = master writes to slave.
REQ-009 in_busDataValid  in  1  write data valid on in_busAddressData.
REQ-010 in_busAddressData  in  32  address on begin; write data otherwise.
REQ-011 in_busBurstSize  in  8  number of words minus 1; sampled on begin.
REQ-012 in_busByteEnable  in  4  byte lanes; sampled on begin.
REQ-013 reg_outBusDataValid  out  1  read data valid.
REQ-014 reg_outBusEndTransaction  out  1  slave ends a read burst or an errored transaction.
REQ-015 reg_outBusError  out  1  transaction rejected.
REQ-016 reg_outBusBusy  out  1  write word is not accepted this cycle.
REQ-017 outBusAddressData  out  32  read data; 0 when reg_outBusDataValid=0.

Function
REQ-018 Hit condition: on begin, address[31:2] minus baseAddress[31:2] is below nrOfEntries. A miss SHALL be ignored: no output activity, state stays IDLE.
REQ-019 Internal word memory: nrOfEntries x 32 bits, byte-writable, synchronous read. Contents are undefined at power-up and are not cleared by reset.
REQ-020 FSM states: IDLE, READ, WRITE, ERROR. On a hit begin, latch word index, remaining count = burstSize, and byte enables.
REQ-021 Range check on begin: if index+burstSize >= nrOfEntries, go to ERROR. In the next cycle, assert reg_outBusError=1 and reg_outBusEndTransaction=1 for 1 cycle, then return to IDLE. No memory write occurs.
REQ-022 READ: the first word appears with reg_outBusDataValid=1 exactly 2 cycles after the begin cycle. After that, one word per cycle for burstSize+1 consecutive cycles, with the index incrementing by 1. Byte enables are ignored.
REQ-023 READ end: reg_outBusEndTransaction=1 for exactly 1 cycle, in the cycle immediately after the last valid word, then IDLE.
REQ-024 WRITE: a word is accepted in a cycle where in_busDataValid=1 and reg_outBusBusy=0. It is written to the current index with the latched byte enables, then the index increments.
REQ-025 A word presented while reg_outBusBusy=1 SHALL NOT be written. The master re-presents it.
REQ-026 Throttle: with writeThrottle=N>0, reg_outBusBusy=1 in the cycle after every Nth accepted word of the transaction. The count restarts on each begin.
REQ-027 WRITE overflow: if an (burstSize+2)th word is presented, discard it and go to ERROR.
REQ-028 WRITE end: in_busEndTransaction=1 returns to IDLE next cycle. Fewer words than burstSize+1 is legal; only the accepted words are written.
REQ-029 in_busEndTransaction during READ aborts the burst: reg_outBusDataValid=0 from the next cycle, no slave end pulse, then IDLE.
REQ-030 in_busBeginTransaction outside IDLE SHALL be ignored.
REQ-031 Simultaneous in_busDataValid and in_busEndTransaction in WRITE: the word is accepted first, then the transaction ends.
REQ-032 All outputs SHALL be registered. reg_outBusError, reg_outBusEndTransaction and reg_outBusBusy are single-cycle pulses.

Reset
REQ-033 While reset=1, and on its assertion at any point including mid-burst: state=IDLE, all reg_out* = 0, outBusAddressData = 0, counters = 0.
REQ-034 A burst interrupted by reset SHALL NOT resume. Words already written remain in memory.

Verification
REQ-035 Write begin addr=baseAddress+8, burstSize=3, byteEnable=F, data 1,2,3,4, then end -> words 2..5 hold 1..4; busy, error and end stay 0.
REQ-036 Read begin addr=baseAddress+8, burstSize=3 -> dataValid in cycles +2..+5 with 1,2,3,4; end pulse at +6; IDLE at +7.
REQ-037 Begin addr=baseAddress+4*510, burstSize=3 -> error=1 and end=1 at cycle +1 only; memory unchanged.
REQ-038 writeThrottle=2, 4 words streamed continuously -> busy high after words 2 and 4; the blocked word is re-presented and all 4 land correctly.
REQ-039 byteEnable=4'b0011, write 32'hAABBCCDD over stored 32'h11223344 -> readback 32'h1122CCDD.
REQ-040 Reset asserted at the 2nd word of an 8-word read -> all outputs 0 within the same cycle; a new begin after reset completes normally.
